// File: rtl/input_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_io_pkg
// Purpose  : Shared constants, helper function and event-state type for the
//            input IO capture cell and its synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
package input_io_pkg;

  // Default build parameters of the capture cell
  localparam int c_sync_stages_def = 2;
  localparam int c_filter_len_def  = 4;

  // Legal parameter ranges; out-of-range values are clamped by the cell
  localparam int c_sync_stages_min = 2;
  localparam int c_sync_stages_max = 4;
  localparam int c_filter_len_min  = 1;
  localparam int c_filter_len_max  = 15;

  // Width of a counter able to hold 0..len
  function automatic int cnt_width(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

  // Pending-event state presented to the fabric
  typedef struct packed {
    logic evt;
    logic pol;
    logic ovf;
  } evt_state_t;

endpackage
`default_nettype wire

// File: rtl/input_io_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : input_io_capture_if
// Purpose  : Pad/fabric-side signal bundle of the input IO capture cell.
//            slave  = the capture cell, master = pad buffer plus fabric.
// Revision : 1.0 - initial release
// ============================================================================
interface input_io_capture_if;
  logic IP;
  logic IQE;
  logic IACK;
  logic IZ;
  logic IQZ;
  logic EVT;
  logic EVT_POL;
  logic OVF;

  modport slave  (input IP, IQE, IACK, output IZ, IQZ, EVT, EVT_POL, OVF);
  modport master (output IP, IQE, IACK, input IZ, IQZ, EVT, EVT_POL, OVF);
endinterface
`default_nettype wire

// File: rtl/input_io_capture_io_sync.sv
`default_nettype none
// ============================================================================
// Module   : io_sync
// Purpose  : STAGES-deep flop chain bringing an asynchronous pad level into
//            the capture clock domain. Asynchronous active-high reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
module io_sync #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d,
  output logic      q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  generate
    if (STAGES == 1) begin : g_single
      // Single stage: the flop samples the pad directly
      always_comb sync_d = d;
    end else begin : g_chain
      // Shift the pad level one stage further each edge
      always_comb sync_d = {sync_q[STAGES-2:0], d};
    end
  endgenerate

  // Chain register, cleared while reset is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/input_io_capture.sv
`default_nettype none
// ============================================================================
// Module   : input_io_capture
// Purpose  : Input IO cell: pad -> synchronizer -> optional glitch filter ->
//            registered level IQZ, plus a held edge-event flag with acknowledge
//            and overflow indication. IZ is the raw pad level.
// Config   : `define INPUT_IO_FILTER_EN to build the glitch filter; without it
//            IQZ follows the synchronized pad whenever IQE is high.
// Revision : 1.0 - initial release
// ============================================================================
module input_io_capture
  import input_io_pkg::*;
#(
  parameter int SYNC_STAGES = c_sync_stages_def,
  parameter int FILTER_LEN  = c_filter_len_def
) (
  input  wire logic           IQC,
  input  wire logic           QRT,
  input_io_capture_if.slave   io
);

  localparam int c_sync_n =
    (SYNC_STAGES < c_sync_stages_min) ? c_sync_stages_min :
    (SYNC_STAGES > c_sync_stages_max) ? c_sync_stages_max : SYNC_STAGES;

`ifdef INPUT_IO_FILTER_EN
  localparam int c_chain_len = c_sync_n;
`else
  // Without a filter the IQZ flop itself is the final synchronizer stage, so
  // the total flop depth from pad to IQZ stays c_sync_n.
  localparam int c_chain_len = c_sync_n - 1;
`endif

  logic       s;
  logic       iqz_q;
  logic       iqz_d;
  logic       chg;
  evt_state_t evt_q;
  evt_state_t evt_d;

  assign io.IZ = io.IP;

  io_sync #(
    .STAGES (c_chain_len)
  ) u_sync (
    .clk (IQC),
    .rst (QRT),
    .d   (io.IP),
    .q   (s)
  );

`ifdef INPUT_IO_FILTER_EN
  localparam int c_filter_n =
    (FILTER_LEN < c_filter_len_min) ? c_filter_len_min :
    (FILTER_LEN > c_filter_len_max) ? c_filter_len_max : FILTER_LEN;
  localparam int c_cnt_w = cnt_width(c_filter_n);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  // Accept a new level only after c_filter_n consecutive enabled differing samples
  always_comb begin
    iqz_d = iqz_q;
    cnt_d = '0;
    if (io.IQE && (s != iqz_q)) begin
      if (cnt_q == c_cnt_w'(c_filter_n - 1)) iqz_d = s;
      else                                    cnt_d = cnt_q + c_cnt_w'(1);
    end
  end

  // Filter run-length counter
  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  // Follow the synchronized pad while enabled, hold otherwise
  always_comb begin
    iqz_d = iqz_q;
    if (io.IQE) iqz_d = s;
  end
`endif

  // Registered fabric level
  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) iqz_q <= 1'b0;
    else     iqz_q <= iqz_d;
  end

  // Event handshake: a level change always raises EVT; an acknowledge on the
  // same edge clears OVF but cannot cancel the new event.
  always_comb begin
    evt_d = evt_q;
    chg   = (iqz_d != iqz_q);
    if (chg) begin
      evt_d.evt = 1'b1;
      evt_d.pol = iqz_d;
      if (io.IACK)        evt_d.ovf = 1'b0;
      else if (evt_q.evt) evt_d.ovf = 1'b1;
    end else if (io.IACK) begin
      evt_d.evt = 1'b0;
      evt_d.ovf = 1'b0;
    end
  end

  // Pending-event register
  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) evt_q <= '0;
    else     evt_q <= evt_d;
  end

  assign io.IQZ     = iqz_q;
  assign io.EVT     = evt_q.evt;
  assign io.EVT_POL = evt_q.pol;
  assign io.OVF     = evt_q.ovf;

endmodule
`default_nettype wire

// File: tb/tb_input_io_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_io_capture
// Purpose  : Self-checking bench for input_io_capture: directed scenarios with
//            literal expectations plus randomized traffic against a
//            behavioural model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_io_capture;
  import input_io_pkg::*;

  localparam int SYNC = c_sync_stages_def;
  localparam int FLEN = c_filter_len_def;
`ifdef INPUT_IO_FILTER_EN
  localparam int LAT  = SYNC + FLEN;  // pad change to IQZ, in edges
  localparam int DLY  = SYNC;         // edges between pad sample and its use
  localparam int NEED = FLEN;         // consecutive differing samples to accept
`else
  localparam int LAT  = SYNC;
  localparam int DLY  = SYNC - 1;
  localparam int NEED = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_io_capture_if bus();

  input_io_capture #(
    .SYNC_STAGES (SYNC),
    .FILTER_LEN  (FLEN)
  ) dut (
    .IQC (clk),
    .QRT (rst),
    .io  (bus)
  );

  int checks = 0;
  int passes = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit m_lvl, m_evt, m_pol, m_ovf;
  bit dq[$];
  int run;

  task automatic model_clear();
    dq.delete();
    for (int i = 0; i < DLY; i++) dq.push_back(1'b0);
    run   = 0;
    m_lvl = 0; m_evt = 0; m_pol = 0; m_ovf = 0;
  endtask

  always @(posedge clk or posedge rst) begin : model
    bit d;
    if (rst) model_clear();
    else begin
      dq.push_back(bus.IP);
      d = dq.pop_front();
      if (bus.IQE && (d != m_lvl)) run++;
      else                         run = 0;
      if (run >= NEED) begin
        m_lvl = d;
        run   = 0;
        m_ovf = bus.IACK ? 1'b0 : (m_evt ? 1'b1 : m_ovf);
        m_evt = 1'b1;
        m_pol = d;
      end else if (bus.IACK) begin
        m_evt = 1'b0;
        m_ovf = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp_iz",  bus.IZ,      bus.IP);
      check("cmp_iqz", bus.IQZ,     m_lvl);
      check("cmp_evt", bus.EVT,     m_evt);
      check("cmp_pol", bus.EVT_POL, m_pol);
      check("cmp_ovf", bus.OVF,     m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic ack();
    bus.IACK = 1'b1;
    tick(1);
    bus.IACK = 1'b0;
  endtask

  initial begin
    logic ipv;
    int hold;
    rst = 1'b1; bus.IP = 1'b0; bus.IQE = 1'b1; bus.IACK = 1'b0;
    tick(1);
    run_cmp = 1'b1;

    // Reset held with the pad toggling
    ipv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.IP = ipv;
      tick(1);
      check("rst_iqz", bus.IQZ, 1'b0);
      check("rst_evt", bus.EVT, 1'b0);
      check("rst_ovf", bus.OVF, 1'b0);
      check("rst_iz",  bus.IZ,  ipv);
      ipv = ~ipv;
    end
    bus.IP = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(LAT + 2);

    // Clean rise, acknowledged at edge 8
    bus.IP = 1'b1;
    tick(LAT - 1);
    check("rise_iqz_early", bus.IQZ, 1'b0);
    tick(1);
    check("rise_iqz", bus.IQZ, 1'b1);
    check("rise_evt", bus.EVT, 1'b1);
    check("rise_pol", bus.EVT_POL, 1'b1);
    tick(7 - LAT);
    bus.IACK = 1'b1;
    tick(1);
    bus.IACK = 1'b0;
    check("ack_evt", bus.EVT, 1'b0);
    check("ack_iqz", bus.IQZ, 1'b1);

    // Fall back to 0, acknowledged
    bus.IP = 1'b0;
    tick(LAT);
    check("fall_iqz", bus.IQZ, 1'b0);
    check("fall_pol", bus.EVT_POL, 1'b0);
    check("fall_ovf", bus.OVF, 1'b0);
    ack();

`ifdef INPUT_IO_FILTER_EN
    // Excursion one sample too short is rejected
    bus.IP = 1'b1;
    tick(FLEN - 1);
    bus.IP = 1'b0;
    tick(LAT + 4);
    check("glitch_iqz", bus.IQZ, 1'b0);
    check("glitch_evt", bus.EVT, 1'b0);
    // Exactly FILTER_LEN samples is accepted, then the fall overflows
    bus.IP = 1'b1;
    tick(FLEN);
    bus.IP = 1'b0;
    tick(LAT - FLEN);
    check("pulse_iqz", bus.IQZ, 1'b1);
    check("pulse_evt", bus.EVT, 1'b1);
    tick(FLEN - 1);
    check("pulse_hold", bus.IQZ, 1'b1);
    check("pulse_no_ovf", bus.OVF, 1'b0);
    tick(1);
`else
    // Single-cycle pulse propagates, fall overflows the pending rise
    bus.IP = 1'b1;
    tick(1);
    bus.IP = 1'b0;
    tick(LAT - 1);
    check("pulse_iqz", bus.IQZ, 1'b1);
    check("pulse_evt", bus.EVT, 1'b1);
    tick(1);
`endif
    check("ovf_iqz", bus.IQZ, 1'b0);
    check("ovf_evt", bus.EVT, 1'b1);
    check("ovf_pol", bus.EVT_POL, 1'b0);
    check("ovf_ovf", bus.OVF, 1'b1);
    ack();
    check("ovf_ack_evt", bus.EVT, 1'b0);
    check("ovf_ack_ovf", bus.OVF, 1'b0);

    // Acknowledge coincident with a change while an event is pending
    bus.IP = 1'b1;
    tick(LAT);
    bus.IP = 1'b0;
    tick(LAT - 1);
    bus.IACK = 1'b1;
    tick(1);
    bus.IACK = 1'b0;
    check("coin_evt", bus.EVT, 1'b1);
    check("coin_pol", bus.EVT_POL, 1'b0);
    check("coin_ovf", bus.OVF, 1'b0);
    ack();

    // Enable gating
    bus.IQE = 1'b0;
    bus.IP  = 1'b1;
    tick(10);
    check("gate_hold", bus.IQZ, 1'b0);
    check("gate_evt",  bus.EVT, 1'b0);
    bus.IQE = 1'b1;
    tick(NEED - 1);
    check("gate_early", bus.IQZ, 1'b0);
    tick(1);
    check("gate_iqz", bus.IQZ, 1'b1);
    check("gate_evt_on", bus.EVT, 1'b1);

    // Mid-operation reset discards pending event and in-flight level
    bus.IP = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_iqz", bus.IQZ, 1'b0);
    check("mid_rst_evt", bus.EVT, 1'b0);
    rst = 1'b0;
    tick(2);

    // Randomized traffic checked by the model every cycle
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        bus.IP = ~bus.IP;
        hold   = $urandom_range(1, 2 * NEED + 3);
      end
      hold--;
      bus.IQE  = ($urandom_range(0, 9) != 0);
      bus.IACK = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0; bus.IACK = 1'b0;
    tick(2);
    run_cmp = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
